// File: rtl/dice_roll_gen_if.sv
// dice_roll_gen_if: result handshake between the dice roller and its display consumer
interface dice_roll_gen_if;
   logic [5:0] result;
   logic       result_valid;
   logic       result_ready;
   modport master (output result, result_valid, input result_ready);
   modport slave (input result, result_valid, output result_ready);
endinterface

// File: rtl/dice_roll_gen.sv
// dice_roll_gen: push-button dice roller (d2..d20) fed by a free-running 16-bit LFSR
// Define DICE_DEBOUNCE_EN to debounce the synchronised button for DB_CYCLES stable cycles.
module dice_roll_gen #(
   parameter int DB_CYCLES     = 1000,
   parameter int TUMBLE_CYCLES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            roll_btn,
   input  logic [2:0]      die_sel,
   output logic            busy,
   dice_roll_gen_if.master res_if
);
   typedef enum logic [1:0] {IDLE, TUMBLE, REDUCE, PRESENT} state_e;
   localparam logic [4:0] N_TAB [8] = '{5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd20, 5'd2, 5'd3};

   if (TUMBLE_CYCLES < 1 || TUMBLE_CYCLES > 65535 || DB_CYCLES < 1) begin : g_bad_params
      $error("dice_roll_gen: parameter out of range");
   end

   state_e      state_q, state_d;
   logic        sync1_q, sync2_q, db_prev_q, db_lvl, trig;
   logic [15:0] lfsr_q, tcnt_q, tcnt_d;
   logic [7:0]  rem_q, rem_d;
   logic [4:0]  n_q, n_d;
   logic [5:0]  result_q, result_d;

`ifdef DICE_DEBOUNCE_EN
   localparam int DBW = $clog2(DB_CYCLES + 1);
   logic           db_q;
   logic [DBW-1:0] dcnt_q;
   // the level flips only after the synchronised input has disagreed with it for DB_CYCLES cycles in a row
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         db_q   <= 1'b0;
         dcnt_q <= '0;
      end else if (sync2_q == db_q) dcnt_q <= '0;
      else if (dcnt_q == DBW'(DB_CYCLES - 1)) begin
         db_q   <= sync2_q;
         dcnt_q <= '0;
      end else dcnt_q <= dcnt_q + 1'b1;
   assign db_lvl = db_q;
`else
   assign db_lvl = sync2_q;
`endif

   assign trig = db_lvl & ~db_prev_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lfsr_q <= 16'hACE1;
      else lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_prev_q <= 1'b0;
         state_q   <= IDLE;
         tcnt_q    <= '0;
         rem_q     <= '0;
         n_q       <= '0;
         result_q  <= '0;
      end else begin
         sync1_q   <= roll_btn;
         sync2_q   <= sync1_q;
         db_prev_q <= db_lvl;
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         rem_q     <= rem_d;
         n_q       <= n_d;
         result_q  <= result_d;
      end

   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      rem_d    = rem_q;
      n_d      = n_q;
      result_d = result_q;
      case (state_q)
         IDLE:
            if (trig) begin
               state_d = TUMBLE;
               n_d     = N_TAB[die_sel];
               tcnt_d  = '0;
            end
         TUMBLE:
            if (tcnt_q == 16'(TUMBLE_CYCLES - 1)) begin
               state_d = REDUCE;
               rem_d   = lfsr_q[7:0];
            end else tcnt_d = tcnt_q + 1'b1;
         REDUCE:
            if (rem_q >= 8'(n_q)) rem_d = rem_q - 8'(n_q);
            else begin
               result_d = 6'(rem_q) + 6'd1;
               state_d  = PRESENT;
            end
         PRESENT: state_d = res_if.result_ready ? IDLE : PRESENT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy                = state_q != IDLE;
      res_if.result_valid = state_q == PRESENT;
      res_if.result       = result_q;
   end
endmodule

// File: tb/tb_dice_roll_gen.sv
// tb_dice_roll_gen: randomized rolls scored against an LFSR-table / modulo reference model
module tb_dice_roll_gen;
   localparam int DB = 4;
   localparam int T = 3;
   localparam int NT [8] = '{4, 6, 8, 10, 12, 20, 2, 3};

   typedef struct {
      int res;
      int n;
      int start;
      int lat;
      int d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       roll_btn = 1'b0;
   logic [2:0] die_sel = 3'd0;
   logic       busy;

   dice_roll_gen_if bus();

   dice_roll_gen #(.DB_CYCLES(DB), .TUMBLE_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .roll_btn(roll_btn), .die_sel(die_sel), .busy(busy), .res_if(bus)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   logic [15:0] tab [65535];
   bit          seen [8][64];
   int          errors = 0, checks = 0, ecnt = 0;
   int          starts = 0, xfers = 0, last_start = 0, last_lat = 0, last_res = 0, held = 0;
   logic        busy_p = 1'b0, val_p = 1'b0, after_x = 1'b0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // rem is the LFSR low byte seen in the last TUMBLE cycle; result = rem mod N + 1
   function automatic exp_t predict(int e, int d);
      int r = int'(tab[(e + T - 1) % 65535][7:0]);
      return '{res: r % NT[d] + 1, n: NT[d], start: e, lat: T + r / NT[d] + 1, d: d};
   endfunction

   function automatic int count_seen(int d);
      int c = 0;
      for (int v = 1; v <= NT[d]; v++) c += int'(seen[d][v]);
      return c;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) ecnt <= 0;
      else ecnt <= ecnt + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_p  <= 1'b0;
         val_p   <= 1'b0;
         after_x <= 1'b0;
      end else begin
         busy_p  <= busy;
         val_p   <= bus.result_valid && !bus.result_ready;
         after_x <= 1'b0;
         if (busy && !busy_p) begin
            q.push_back(predict(ecnt, int'(die_sel)));
            starts     <= starts + 1;
            last_start <= ecnt;
         end
         if (after_x) begin
            check("valid_after_xfer", int'(bus.result_valid), 0);
            check("busy_after_xfer", int'(busy), 0);
            check("result_retained", int'(bus.result), last_res);
         end
         if (bus.result_valid) begin
            if (val_p) check("result_held", int'(bus.result), held);
            else if (q.size() == 0) check("spurious_valid", 1, 0);
            else begin
               check("latency", ecnt - q[0].start, q[0].lat);
               last_lat <= ecnt - q[0].start;
            end
            held <= int'(bus.result);
            if (bus.result_ready && q.size() != 0) begin
               check("result", int'(bus.result), q[0].res);
               check("range", int'(bus.result >= 6'd1 && int'(bus.result) <= q[0].n), 1);
               seen[q[0].d][bus.result] <= 1'b1;
               last_res <= int'(bus.result);
               after_x  <= 1'b1;
               xfers    <= xfers + 1;
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_xfer(int x0);
      for (int i = 0; i < 600 && xfers == x0; i++) cyc(1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 600 && busy; i++) cyc(1);
      check("idle_reached", int'(busy), 0);
      cyc(DB + 6);
   endtask

   task automatic roll(int d);
      int x0 = xfers;
      die_sel  = 3'(d);
      roll_btn = 1'b1;
      cyc(DB + 4);
      roll_btn = 1'b0;
      wait_xfer(x0);
      check("roll_done", xfers - x0, 1);
      cyc(DB + 4);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, x0, p, lat, k;
      tab[0] = 16'hACE1;
      for (int i = 1; i < 65535; i++)
         tab[i] = {tab[i-1][0] ^ tab[i-1][2] ^ tab[i-1][3] ^ tab[i-1][5], tab[i-1][15:1]};
      bus.result_ready = 1'b1;
      cyc(3);
      check("reset_result", int'(bus.result), 0);
      check("reset_valid", int'(bus.result_valid), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      cyc(5);

      // single long press on a d20; also measures press-to-start latency
      s0 = starts; x0 = xfers;
      die_sel = 3'd5; p = ecnt; roll_btn = 1'b1;
      cyc(20);
      roll_btn = 1'b0;
      wait_xfer(x0);
      cyc(20);
      lat = last_start - p;
      check("long_press_one_roll", xfers - x0, 1);
      check("long_press_one_start", starts - s0, 1);
      check("long_press_busy_low", int'(busy), 0);

      // die_sel changes after the latch must not matter
      s0 = starts; x0 = xfers;
      die_sel = 3'd0; roll_btn = 1'b1;
      for (int i = 0; i < 100 && starts == s0; i++) cyc(1);
      die_sel = 3'd5;
      cyc(DB + 4);
      roll_btn = 1'b0;
      wait_xfer(x0);
      check("latched_die_range", int'(last_res >= 1 && last_res <= 4), 1);
      cyc(DB + 4);

      // time the press so the sampled LFSR byte is 255 on a d4
      k = ecnt + 5;
      while (tab[(k + lat + T - 1) % 65535][7:0] != 8'hFF) k++;
      while (ecnt < k) cyc(1);
      roll(0);
      check("worst_case_result", last_res, 4);
      check("worst_case_latency", last_lat, T + 64);

      // consumer stalls 50 cycles in PRESENT while the button is pressed again
      s0 = starts; x0 = xfers;
      bus.result_ready = 1'b0; die_sel = 3'd2; roll_btn = 1'b1;
      cyc(DB + 4);
      roll_btn = 1'b0;
      for (int i = 0; i < 400 && !bus.result_valid; i++) cyc(1);
      check("stall_valid_up", int'(bus.result_valid), 1);
      for (int i = 0; i < 50; i++) begin
         roll_btn = (i >= 5 && i < 5 + DB + 4);
         cyc(1);
      end
      check("stall_valid_held", int'(bus.result_valid), 1);
      bus.result_ready = 1'b1;
      wait_xfer(x0);
      cyc(30);
      check("stall_single_roll", starts - s0, 1);
      check("stall_single_xfer", xfers - x0, 1);

      // bouncing button: 2-cycle toggles
      s0 = starts;
      die_sel = 3'(($urandom % 8));
      for (int i = 0; i < 5; i++) begin
         roll_btn = 1'b1; cyc(2);
         roll_btn = 1'b0; cyc(2);
      end
      cyc(20);
      wait_idle();
`ifdef DICE_DEBOUNCE_EN
      check("bounce_no_trigger", starts - s0, 0);
`else
      check("bounce_triggers", int'(starts > s0), 1);
`endif

      // reset during TUMBLE aborts the roll
      s0 = starts; x0 = xfers;
      die_sel = 3'd1; roll_btn = 1'b1;
      for (int i = 0; i < 100 && starts == s0; i++) cyc(1);
      check("abort_started", starts - s0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_result_zero", int'(bus.result), 0);
      check("abort_valid_zero", int'(bus.result_valid), 0);
      check("abort_busy_zero", int'(busy), 0);
      roll_btn = 1'b0;
      q.delete();
      cyc(3);
      rst_n = 1'b1;
      cyc(200);
      check("abort_no_result", xfers - x0, 0);
      check("abort_no_restart", starts - s0, 1);

      // button held across reset release gives exactly one roll
      s0 = starts; x0 = xfers;
      die_sel = 3'd4; roll_btn = 1'b1;
      cyc(2);
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      wait_xfer(x0);
      cyc(40);
      roll_btn = 1'b0;
      cyc(30);
      check("held_reset_one_roll", starts - s0, 1);
      check("held_reset_one_xfer", xfers - x0, 1);

      // coverage of every face for every die
      for (int d = 0; d < 8; d++)
         for (int v = 0; v < 64; v++) seen[d][v] = 1'b0;
      for (int d = 0; d < 8; d++) begin
         for (int r = 0; r < 250; r++) begin
            roll(d);
            cyc($urandom_range(0, 7));
            if (r >= 9 && count_seen(d) == NT[d]) break;
         end
         check("face_coverage", count_seen(d), NT[d]);
      end
      check("scoreboard_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dice_roll_gen.md
DICE_ROLL_GEN -- requirements
Module: dice_roll_gen

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000: cycles the synchronised button must stay stable before its debounced level changes.
REQ-002 SHALL have parameter TUMBLE_CYCLES, default 64: cycles spent in TUMBLE before sampling; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port roll_btn, input, 1: raw asynchronous roll push-button, active-high.
REQ-006 SHALL have port die_sel, input, 3: die type: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d2, 7=d3.
REQ-007 SHALL have port result, output, 6: rolled value, binary, 1..N; feeds the seven-segment display random_number input.
REQ-008 SHALL have port result_valid, output, 1: result is valid and held stable.
REQ-009 SHALL have port result_ready, input, 1: display consumer accepts result.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-011 SHALL pass roll_btn through a two-flop synchroniser, then debounce it; a roll trigger is the rising edge of the debounced level.
REQ-012 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle in all states and never reaches zero.
REQ-013 SHALL implement FSM IDLE -> TUMBLE -> REDUCE -> PRESENT -> IDLE.
REQ-014 IDLE: on trigger, latch die_sel into N (per REQ-006) and enter TUMBLE next cycle; die_sel changes after the latch have no effect on that roll.
REQ-015 TUMBLE: SHALL stay exactly TUMBLE_CYCLES cycles, then load rem = LFSR[7:0] and enter REDUCE.
REQ-016 REDUCE: each cycle with rem >= N SHALL subtract N; when rem < N, result <= rem+1 and the FSM enters PRESENT; worst case 64 cycles (d4, rem=255).
REQ-017 PRESENT: result_valid SHALL be 1 and result stable until a cycle with result_ready=1; that cycle is the transfer, and the FSM enters IDLE next cycle with result_valid=0.
REQ-018 After the transfer, result SHALL retain the last rolled value until the next roll completes.
REQ-019 Triggers outside IDLE SHALL be ignored, not queued; result_ready outside PRESENT SHALL be ignored.
REQ-020 A trigger in the same cycle PRESENT returns to IDLE SHALL be ignored.
REQ-021 result SHALL always lie in 1..N for the latched die; modulo bias is accepted.

Reset
REQ-022 rst_n low SHALL immediately force: state=IDLE, result=0, result_valid=0, busy=0, LFSR=16'hACE1, synchroniser/debounce state=0, debounce counter=0.
REQ-023 Reset asserted mid-roll SHALL abort the roll; no result_valid pulse follows release.
REQ-024 Button held high across reset release SHALL produce one trigger after DB_CYCLES of stable high.

Configuration
REQ-025 With macro DICE_DEBOUNCE_EN defined, SHALL debounce per REQ-001.
REQ-026 Without DICE_DEBOUNCE_EN, SHALL omit the debounce counter; the debounced level equals the synchroniser output, and DB_CYCLES is unused.

Verification
REQ-027 DB_CYCLES=4, TUMBLE_CYCLES=3, die_sel=5; press roll_btn for 20 cycles, result_ready=1 -> exactly one result_valid pulse, result in 1..20, busy low after the transfer.
REQ-028 Same parameters; toggle roll_btn every 2 cycles for 20 cycles, then release -> no trigger with DICE_DEBOUNCE_EN; triggers without it.
REQ-029 die_sel=0; force rem=255 via an LFSR probe -> REDUCE lasts 64 cycles and result=4.
REQ-030 result_ready=0 for 50 cycles in PRESENT, with a second press during the wait -> result_valid and result held stable for all 50 cycles; the second press causes no extra roll.
REQ-031 rst_n pulsed low during TUMBLE -> outputs go to 0 asynchronously; no result_valid pulse follows release.
REQ-032 1000 rolls per die_sel value 0..7 -> every result lies in 1..N and every value in 1..N occurs at least once.
